// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser with optional parity bit.
module uart_tx #(
  parameter int unsigned clkFreq    = 25000000,
  parameter int unsigned baudRate   = 115200,
  parameter logic        if_parity  = 1'b0,
  parameter logic        odd_parity = 1'b0,
  parameter int unsigned fifoDepth  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_ovf,
  output logic       o_uart_tx
);

  localparam int unsigned DIV = clkFreq / baudRate;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int unsigned OW  = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]    mem [fifoDepth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] count, count_n;
  logic          push, pop, empty;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          tx_n;
  logic          tick;

  assign push  = i_wr && !o_full;
  assign empty = (count == '0);
  assign tick  = (cnt == CW'(DIV - 1));

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Next-state, pop decision and next line level
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    tx_n    = o_uart_tx;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          par_n   = (^mem[rd_ptr]) ^ odd_parity;
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_DATA;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            if (if_parity) begin
              state_n = S_PARITY;
              tx_n    = par;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_n = '0;
          idx_n = '0;
          if (!empty) begin
            // back-to-back: next start bit follows the stop bit directly
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            par_n   = (^mem[rd_ptr]) ^ odd_parity;
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + OW'(1);
      2'b01:   count_n = count - OW'(1);
      default: count_n = count;
    endcase
  end

  // State, FIFO pointers and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      par       <= 1'b0;
      o_uart_tx <= 1'b1;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      o_full    <= 1'b0;
      o_busy    <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      par       <= par_n;
      o_uart_tx <= tx_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      o_full    <= (count_n == OW'(fifoDepth));
      o_busy    <= (state_n != S_IDLE) || (count_n != '0);
      o_ovf     <= i_wr && o_full;
    end
  end

endmodule
